// File: rtl/prog_ram_pkg.sv
// Shared definitions for the RGBY program memory: default sizes, state encoding
// and the built-in boot image copied into RAM after every reset.
package prog_ram_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 12;
    localparam int DEF_BOOT_LEN   = 57;
    localparam int IMAGE_LEN      = 57;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    // Current development program; edit here only, the FSM never sees the table.
    localparam logic [11:0] BOOT_IMAGE [IMAGE_LEN] = '{
        12'h0F9, 12'h1A0, 12'h9F1, 12'hE09, 12'h2C4, 12'hB03, 12'h3D1, 12'h740,
        12'h0F2, 12'h8A5, 12'h4E0, 12'hC17, 12'h5B2, 12'h930, 12'h6A8, 12'hD01,
        12'h1F3, 12'h2E4, 12'h7C0, 12'hA55, 12'h3B6, 12'h8F0, 12'h4C9, 12'hE12,
        12'h0A7, 12'h5D3, 12'hB40, 12'h6E1, 12'h9C8, 12'h1B5, 12'hC70, 12'h2A6,
        12'hF00, 12'h3E9, 12'h7D2, 12'h0C4, 12'h8B1, 12'h4F7, 12'hD28, 12'h5A0,
        12'hA36, 12'h1C9, 12'hE54, 12'h6B3, 12'h2D7, 12'h9E0, 12'h3A1, 12'hB8C,
        12'h7F5, 12'h0D6, 12'hC23, 12'h4A9, 12'hF10, 12'h8C7, 12'h5E2, 12'h000,
        12'h000
    };

endpackage

// File: rtl/prog_ram_boot_rom.sv
// Combinational boot-image lookup: word = image[idx] for idx < BOOT_LEN, else 0.
module prog_ram_boot_rom
    import prog_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BOOT_LEN   = DEF_BOOT_LEN
) (
    input  logic [ADDR_WIDTH:0]   idx,
    output logic [DATA_WIDTH-1:0] word
);

    // Compare-and-select keeps the index width independent of the table size.
    always_comb begin
        word = '0;
        for (int i = 0; i < IMAGE_LEN; i++) begin
            if (i < BOOT_LEN && idx == (ADDR_WIDTH+1)'(i)) begin
                word = DATA_WIDTH'(BOOT_IMAGE[i]);
            end
        end
    end

endmodule

// File: rtl/prog_ram_loader.sv
// RGBY program RAM with boot-image copy and streaming reload port.
// Optional macro PROG_RAM_WRITE_PROTECT_EN blocks CPU writes over the boot area.
//
// state   | meaning
// BOOT    | copy boot image, zero-fill the rest, one word per cycle
// RUN     | CPU owns the RAM, registered read-first access
// LOAD    | stream words into RAM from address 0 until ld_last or top
module prog_ram_loader
    import prog_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BOOT_LEN   = DEF_BOOT_LEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  write_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  busy,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  ld_done
`ifdef PROG_RAM_WRITE_PROTECT_EN
    ,
    output logic                  wp_err
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_PTR = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);

    state_t                state;
    logic [ADDR_WIDTH:0]   ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] boot_word;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

`ifdef PROG_RAM_WRITE_PROTECT_EN
    localparam logic [ADDR_WIDTH:0] BOOT_END = (ADDR_WIDTH+1)'(BOOT_LEN);
    logic wp_block;
    assign wp_block = ({1'b0, addr} < BOOT_END);
`endif

    prog_ram_boot_rom #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BOOT_LEN   (BOOT_LEN)
    ) u_boot_rom (
        .idx  (ptr),
        .word (boot_word)
    );

    // Single write port shared by boot copy, CPU and loader.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = din;
        if (!reset) begin
            case (state)
                ST_BOOT: begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr[ADDR_WIDTH-1:0];
                    mem_wdata = boot_word;
                end
                ST_RUN: begin
`ifdef PROG_RAM_WRITE_PROTECT_EN
                    mem_we = write_en && !wp_block;
`else
                    mem_we = write_en;
`endif
                end
                ST_LOAD: begin
                    mem_we    = ld_valid;
                    mem_waddr = ptr[ADDR_WIDTH-1:0];
                    mem_wdata = ld_data;
                end
                default: mem_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_BOOT;
            ptr      <= '0;
            dout     <= '0;
            busy     <= 1'b1;
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
`ifdef PROG_RAM_WRITE_PROTECT_EN
            wp_err   <= 1'b0;
`endif
        end else begin
            ld_done <= 1'b0;
`ifdef PROG_RAM_WRITE_PROTECT_EN
            wp_err  <= 1'b0;
`endif
            case (state)
                ST_BOOT: begin
                    ptr <= ptr + PTR_ONE;
                    if (ptr == LAST_PTR) begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                        ptr   <= '0;
                    end
                end
                ST_RUN: begin
`ifdef PROG_RAM_WRITE_PROTECT_EN
                    wp_err <= write_en && wp_block;
`endif
                    if (ld_start) begin
                        state    <= ST_LOAD;
                        ptr      <= '0;
                        busy     <= 1'b1;
                        ld_ready <= 1'b1;
                        dout     <= '0;
                    end else begin
                        dout <= mem[addr];
                    end
                end
                ST_LOAD: begin
                    if (ld_valid) begin
                        ptr <= ptr + PTR_ONE;
                        // Stop at the top word so a long stream never wraps onto address 0.
                        if (ld_last || ptr == LAST_PTR) begin
                            state    <= ST_RUN;
                            busy     <= 1'b0;
                            ld_ready <= 1'b0;
                            ld_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_BOOT;
                    ptr   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_ram_loader.sv
// Directed bench for prog_ram_loader with a word-level memory model checked every cycle.
module tb_prog_ram_loader;

    localparam int DEPTH = 256;
    localparam int BLEN  = 57;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  addr = '0;
    logic [11:0] din = '0;
    logic        write_en = 1'b0;
    logic [11:0] dout;
    logic        busy;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [11:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        ld_done;
`ifdef PROG_RAM_WRITE_PROTECT_EN
    logic        wp_err;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    prog_ram_loader dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .din      (din),
        .write_en (write_en),
        .dout     (dout),
        .busy     (busy),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .ld_done  (ld_done)
`ifdef PROG_RAM_WRITE_PROTECT_EN
        ,
        .wp_err   (wp_err)
`endif
    );

    logic [11:0] img [57] = '{
        12'h0F9, 12'h1A0, 12'h9F1, 12'hE09, 12'h2C4, 12'hB03, 12'h3D1, 12'h740,
        12'h0F2, 12'h8A5, 12'h4E0, 12'hC17, 12'h5B2, 12'h930, 12'h6A8, 12'hD01,
        12'h1F3, 12'h2E4, 12'h7C0, 12'hA55, 12'h3B6, 12'h8F0, 12'h4C9, 12'hE12,
        12'h0A7, 12'h5D3, 12'hB40, 12'h6E1, 12'h9C8, 12'h1B5, 12'hC70, 12'h2A6,
        12'hF00, 12'h3E9, 12'h7D2, 12'h0C4, 12'h8B1, 12'h4F7, 12'hD28, 12'h5A0,
        12'hA36, 12'h1C9, 12'hE54, 12'h6B3, 12'h2D7, 12'h9E0, 12'h3A1, 12'hB8C,
        12'h7F5, 12'h0D6, 12'hC23, 12'h4A9, 12'hF10, 12'h8C7, 12'h5E2, 12'h000,
        12'h000
    };

    // Model: memory contents plus expected outputs after each rising edge.
    logic [11:0] m_mem [DEPTH];
    int          m_boot_left;
    bit          m_loading;
    int          m_ptr;
    bit          m_blocked;
    logic [11:0] e_dout;
    logic        e_busy, e_ldr, e_done, e_wp;

    task automatic check12(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %03h expected %03h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkint(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = (i < BLEN) ? img[i] : 12'h000;
            m_boot_left = DEPTH;
            m_loading = 1'b0;
            m_ptr = 0;
            e_dout = '0; e_busy = 1'b1; e_ldr = 1'b0; e_done = 1'b0; e_wp = 1'b0;
        end else begin
            e_done = 1'b0;
            e_wp = 1'b0;
            if (m_boot_left > 0) begin
                m_boot_left--;
                if (m_boot_left == 0) e_busy = 1'b0;
            end else if (m_loading) begin
                if (ld_valid) begin
                    m_mem[m_ptr] = ld_data;
                    m_ptr++;
                    if (ld_last || m_ptr == DEPTH) begin
                        m_loading = 1'b0;
                        e_done = 1'b1; e_busy = 1'b0; e_ldr = 1'b0;
                    end
                end
            end else begin
                m_blocked = 1'b0;
`ifdef PROG_RAM_WRITE_PROTECT_EN
                m_blocked = write_en && (int'(addr) < BLEN);
                e_wp = m_blocked;
`endif
                if (ld_start) begin
                    e_dout = '0;
                    m_loading = 1'b1;
                    m_ptr = 0;
                    e_busy = 1'b1; e_ldr = 1'b1;
                end else begin
                    e_dout = m_mem[addr];
                end
                if (write_en && !m_blocked) m_mem[addr] = din;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check12("dout", dout, e_dout);
        check1("busy", busy, e_busy);
        check1("ld_ready", ld_ready, e_ldr);
        check1("ld_done", ld_done, e_done);
`ifdef PROG_RAM_WRITE_PROTECT_EN
        check1("wp_err", wp_err, e_wp);
`endif
    end

    task automatic wait_boot(input string name);
        int n = 0;
        while (n < 400) begin
            @(posedge clk); #1;
            n++;
            if (!busy) break;
        end
        checkint(name, n, 256);
    endtask

    task automatic rd(input logic [7:0] a, input logic [11:0] exp, input string name);
        @(negedge clk);
        addr = a; write_en = 1'b0;
        @(posedge clk); #1;
        check12(name, dout, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [11:0] d);
        @(negedge clk);
        addr = a; din = d; write_en = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        write_en = 1'b0;
    endtask

    task automatic ld_word(input logic [11:0] d, input logic l);
        @(negedge clk);
        ld_valid = 1'b1; ld_data = d; ld_last = l;
        @(posedge clk); #1;
    endtask

    task automatic ld_begin();
        @(negedge clk);
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        check1("reset_busy", busy, 1'b1);
        check12("reset_dout", dout, 12'h000);
        reset = 1'b0;
        wait_boot("boot_cycles");
        check12("model_word0", m_mem[0], 12'h0F9);
        check12("model_word32", m_mem[32], 12'hF00);

        rd(8'd0, 12'h0F9, "rd_addr0");
        rd(8'd2, 12'h9F1, "rd_addr2");
        rd(8'd32, 12'hF00, "rd_addr32");
        rd(8'd200, 12'h000, "rd_addr200");

        @(negedge clk);
        addr = 8'd5; din = 12'hABC; write_en = 1'b1;
        @(posedge clk); #1;
        check12("rd_first_old", dout, 12'hB03);
        @(negedge clk);
        write_en = 1'b0;
        @(posedge clk); #1;
        check12("rd_after_write", dout, 12'hABC);

        ld_begin();
        check1("load_busy", busy, 1'b1);
        check1("load_ready", ld_ready, 1'b1);
        ld_word(12'h111, 1'b0);
        ld_word(12'h222, 1'b0);
        @(negedge clk); ld_valid = 1'b0;
        @(negedge clk); ld_valid = 1'b0;
        ld_word(12'h333, 1'b1);
        check1("ld_done_short", ld_done, 1'b1);
        @(negedge clk); ld_valid = 1'b0; ld_last = 1'b0;
        check1("busy_after_load", busy, 1'b0);
        rd(8'd0, 12'h111, "load_addr0");
        rd(8'd1, 12'h222, "load_addr1");
        rd(8'd2, 12'h333, "load_addr2");
        rd(8'd3, 12'hE09, "load_addr3_kept");

        ld_begin();
        for (int i = 0; i < 256; i++) begin
            ld_word(12'(i * 7 + 1), 1'b0);
            if (i == 254) check1("no_done_before_top", ld_done, 1'b0);
        end
        check1("ld_done_full", ld_done, 1'b1);
        ld_word(12'hFFF, 1'b0);
        @(negedge clk); ld_valid = 1'b0;
        rd(8'd0, 12'h001, "full_no_wrap");
        rd(8'd255, 12'h6FA, "full_top");

        ld_begin();
        for (int i = 0; i < 10; i++) ld_word(12'h5A0 + 12'(i), 1'b0);
        @(negedge clk);
        ld_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_boot("reboot_cycles");
        rd(8'd0, 12'h0F9, "reboot_addr0");
        rd(8'd5, 12'hB03, "reboot_addr5");
        rd(8'd9, 12'h8A5, "reboot_addr9");

`ifdef PROG_RAM_WRITE_PROTECT_EN
        @(negedge clk);
        addr = 8'd3; din = 12'h777; write_en = 1'b1;
        @(posedge clk); #1;
        check1("wp_err_pulse", wp_err, 1'b1);
        @(negedge clk);
        write_en = 1'b0;
        rd(8'd3, 12'hE09, "wp_addr3_kept");
        @(negedge clk);
        addr = 8'd100; din = 12'h4D2; write_en = 1'b1;
        @(posedge clk); #1;
        check1("wp_err_quiet", wp_err, 1'b0);
        @(negedge clk);
        write_en = 1'b0;
        rd(8'd100, 12'h4D2, "wp_addr100");
`else
        wr(8'd3, 12'h777);
        rd(8'd3, 12'h777, "nowp_addr3");
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
